sccb_init_sequencer: RTL

Register-table sequencer that configures the OV5640 cameras through the existing SCCB write engine. On `go` it waits for camera power-up, walks an external synchronous ROM of {16-bit register address, 8-bit data} entries, and issues one SCCB write per entry using the engine's start/ready handshake. It drives the camera-select field so that the engine's bus steering targets camera 0, camera 1 or both, and it supports in-table delay and end markers.

---
 rtl/sccb_seq_pkg.sv | 37 +++
 rtl/sccb_seq_timer.sv | 27 ++
 rtl/sccb_init_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sccb_seq_pkg.sv
// Shared constants for the SCCB init-table sequencer: state codes, table markers,
// camera steering codes and a timer sizing helper.
package sccb_seq_pkg;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t S_IDLE       = 4'd0;
    localparam seq_state_t S_STARTUP    = 4'd1;
    localparam seq_state_t S_FETCH      = 4'd2;
    localparam seq_state_t S_DECODE     = 4'd3;
    localparam seq_state_t S_ISSUE      = 4'd4;
    localparam seq_state_t S_WAIT_ACK   = 4'd5;
    localparam seq_state_t S_WAIT_READY = 4'd6;
    localparam seq_state_t S_DELAY      = 4'd7;
    localparam seq_state_t S_DONE       = 4'd8;
    localparam seq_state_t S_ERROR      = 4'd9;

    localparam logic [15:0] SEQ_DELAY_MARK = 16'hFFFF;
    localparam logic [15:0] SEQ_END_MARK   = 16'hFFFE;

    localparam logic [1:0] CAM_BOTH = 2'b00;
    localparam logic [1:0] CAM_0    = 2'b01;
    localparam logic [1:0] CAM_1    = 2'b10;
    localparam logic [1:0] CAM_NONE = 2'b11;

    // Largest value the shared timer ever has to hold.
    function automatic int unsigned timer_span(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sccb_seq_timer.sv
// Loadable down-counter shared by startup wait, delay markers and ack timeout.
// last is high while the count is 0 or 1, i.e. on the final cycle of a loaded interval.
module sccb_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last = (cnt <= W'(1));

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a {reg addr, data} ROM table and issues one SCCB engine write per entry,
// honouring delay/end markers, with power-up wait and ack timeout.
module sccb_init_sequencer
    import sccb_seq_pkg::*;
#(
    parameter int unsigned ROM_AW       = 8,
    parameter int unsigned STARTUP_WAIT = 200_000,
    parameter int unsigned TICK_CYCLES  = 100_000,
    parameter int unsigned ACK_TIMEOUT  = 4096
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              go,
    input  logic [1:0]        cam_sel,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              start_ov5640,
    output logic [15:0]       address_ov5640,
    output logic [7:0]        data_ov5640,
    input  logic              ready_ov5640,
    output logic [1:0]        select_initial_cam,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW:0]   wr_count
);

    localparam int unsigned TMR_MAX = timer_span(STARTUP_WAIT, 255 * TICK_CYCLES, ACK_TIMEOUT);
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam int unsigned CW      = ROM_AW + 1;

    seq_state_t     state;
    logic [15:0]    entry_addr;
    logic [7:0]     entry_data;
    logic           is_delay;
    logic           is_end;
    logic           go_ok;
    logic           adv;
    logic           at_last;
    logic           tmr_load;
    logic [TW-1:0]  tmr_val;
    logic           tmr_last;

    assign entry_addr = rom_data[23:8];
    assign entry_data = rom_data[7:0];
    assign is_delay   = (entry_addr == SEQ_DELAY_MARK);
    assign is_end     = (entry_addr == SEQ_END_MARK);
    assign at_last    = &rom_addr;
    assign go_ok      = go && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

    assign start_ov5640 = (state == S_ISSUE);

    // Points where the current entry is finished and the walk moves on.
    assign adv = ((state == S_DECODE) && is_delay && (entry_data == 8'd0)) ||
                 ((state == S_WAIT_READY) && ready_ov5640) ||
                 ((state == S_DELAY) && tmr_last);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (go_ok) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(STARTUP_WAIT);
        end else if ((state == S_DECODE) && is_delay && (entry_data != 8'd0)) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(entry_data) * TW'(TICK_CYCLES);
        end else if (state == S_ISSUE) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(ACK_TIMEOUT);
        end
    end

    sccb_seq_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk_sys),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last     (tmr_last)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state              <= S_IDLE;
            rom_addr           <= '0;
            address_ov5640     <= '0;
            data_ov5640        <= '0;
            select_initial_cam <= CAM_NONE;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            wr_count           <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (go) begin
                        state              <= S_STARTUP;
                        done               <= 1'b0;
                        error              <= 1'b0;
                        wr_count           <= '0;
                        rom_addr           <= '0;
                        select_initial_cam <= cam_sel;
                        busy               <= 1'b1;
                    end
                end
                S_STARTUP: begin
                    if (tmr_last) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_delay) begin
                        if (entry_data != 8'd0) state <= S_DELAY;
                    end else if (is_end) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (ready_ov5640) begin
                        address_ov5640 <= entry_addr;
                        data_ov5640    <= entry_data;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wr_count <= wr_count + CW'(1);
                    state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!ready_ov5640) begin
                        state <= S_WAIT_READY;
                    end else if (tmr_last) begin
                        state              <= S_ERROR;
                        error              <= 1'b1;
                        busy               <= 1'b0;
                        select_initial_cam <= CAM_NONE;
                    end
                end
                S_WAIT_READY, S_DELAY: begin
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Stepping past the last table slot ends the run rather than wrapping.
            if (adv) begin
                if (at_last) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    rom_addr <= rom_addr + ROM_AW'(1);
                    state    <= S_FETCH;
                end
            end
        end
    end

endmodule
